// File: rtl/alu_pkg.sv
// Shared opcode, width and command-word definitions for the ALU command path.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam int CMD_W = 10;
  localparam int RES_W = 5;

  // Field order matches the ALU input bus: {op, b, a}.
  typedef struct packed {
    logic [1:0] op;
    logic [3:0] b;
    logic [3:0] a;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_OUT   = 2'd2
  } feeder_state_t;

  // Only arithmetic ops produce a meaningful carry/borrow bit.
  function automatic logic op_has_flag(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_feeder_if.sv
// Command and result handshakes between a requester and the ALU command feeder.
interface alu_cmd_feeder_if;

  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_a;
  logic [3:0] in_b;

  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_flag;
  logic [1:0] out_op;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_flag, out_op
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_flag, out_op
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO with wrap-bit pointers; read data is the head entry, valid when !empty.
// Writes are dropped when full and pops when empty; no full-bypass on a popping cycle.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

endmodule

// File: rtl/alu_cmd_feeder.sv
// Buffers ALU commands, holds each on the ALU bus SETTLE cycles, returns the registered result.
// Latency SETTLE+1 edges from accept when idle; in_ready drops when the FIFO is full; result holds until out_ready.
module alu_cmd_feeder
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_feeder_if.slave  bus,
  output logic [CMD_W-1:0] alu_cmd_o,
  output logic             alu_drive,
  input  logic [RES_W-1:0] alu_res_i
);

  localparam int CW = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  feeder_state_t state;
  cmd_t          cur;
  cmd_t          wcmd;
  logic [CMD_W-1:0] head;
  logic [CW-1:0] cnt;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          res_taken;

  assign wcmd      = '{op: bus.in_op, b: bus.in_b, a: bus.in_a};
  assign fifo_push = bus.in_valid && bus.in_ready;
  assign res_taken = (state == ST_OUT) && bus.out_valid && bus.out_ready;
  // Pop feeds the DRIVE entry from either IDLE or a consumed result.
  assign fifo_pop  = !fifo_empty && ((state == ST_IDLE) || res_taken);

  assign bus.in_ready = !fifo_full;
  assign alu_cmd_o    = cur;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (wcmd),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cur           <= '0;
      alu_drive     <= 1'b0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_flag  <= 1'b0;
      bus.out_op    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur       <= head;
            alu_drive <= 1'b1;
            cnt       <= CNT_INIT;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            bus.out_data  <= alu_res_i[3:0];
            bus.out_flag  <= op_has_flag(cur.op) && alu_res_i[4];
            bus.out_op    <= cur.op;
            bus.out_valid <= 1'b1;
            alu_drive     <= 1'b0;
            state         <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (res_taken) begin
            bus.out_valid <= 1'b0;
            if (!fifo_empty) begin
              cur       <= head;
              alu_drive <= 1'b1;
              cnt       <= CNT_INIT;
              state     <= ST_DRIVE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_feeder.sv
// Directed bench for alu_cmd_feeder with a behavioural 4-bit ALU on the command bus.
module tb_alu_cmd_feeder;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] alu_cmd;
  logic       alu_drive;
  logic [4:0] alu_res;
  int passed = 0;
  int total  = 0;

  alu_cmd_feeder_if bus();

  alu_cmd_feeder #(.DEPTH(4), .SETTLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_cmd_o (alu_cmd),
    .alu_drive (alu_drive),
    .alu_res_i (alu_res)
  );

  always #5 clk = ~clk;

  // ALU model; logic ops raise bit4 on purpose, and an idle bus returns junk.
  always_comb begin
    alu_res = 5'h1F;
    if (alu_drive) begin
      case (alu_cmd[9:8])
        2'b00:   alu_res = {1'b0, alu_cmd[3:0]} + {1'b0, alu_cmd[7:4]};
        2'b01:   alu_res = {1'b0, alu_cmd[3:0]} - {1'b0, alu_cmd[7:4]};
        2'b10:   alu_res = {1'b1, alu_cmd[3:0] & alu_cmd[7:4]};
        default: alu_res = {1'b1, alu_cmd[3:0] ^ alu_cmd[7:4]};
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, output bit ok);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    ok = bus.in_ready;
    if (ok) step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      step();
      n++;
    end
    ok = bus.out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (alu_cmd !== 10'd0) $display("FAIL rst_cmd got %h want 000", alu_cmd); else passed++;
    total++; if (alu_drive !== 1'b0) $display("FAIL rst_drive got %b want 0", alu_drive); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 4'd0) $display("FAIL rst_out_data got %h want 0", bus.out_data); else passed++;
    total++; if (bus.out_flag !== 1'b0) $display("FAIL rst_out_flag got %b want 0", bus.out_flag); else passed++;
    total++; if (bus.out_op !== 2'd0) $display("FAIL rst_out_op got %b want 00", bus.out_op); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_a = 4'd5; bus.in_b = 4'd3;
    step();
    bus.in_valid = 1'b0;
    total++; if (alu_drive !== 1'b0) $display("FAIL basic_drive_k got %b want 0", alu_drive); else passed++;
    step();
    total++; if (alu_drive !== 1'b1) $display("FAIL basic_drive_k1 got %b want 1", alu_drive); else passed++;
    total++; if (alu_cmd !== 10'b00_0011_0101) $display("FAIL basic_cmd got %b want 0000110101", alu_cmd); else passed++;
    step();
    total++; if (alu_drive !== 1'b1) $display("FAIL basic_drive_k2 got %b want 1", alu_drive); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_valid_k2 got %b want 0", bus.out_valid); else passed++;
    step();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid_k3 got %b want 1", bus.out_valid); else passed++;
    total++; if (alu_drive !== 1'b0) $display("FAIL basic_drive_k3 got %b want 0", alu_drive); else passed++;
    total++; if (bus.out_data !== 4'd8) $display("FAIL basic_data got %h want 8", bus.out_data); else passed++;
    total++; if (bus.out_flag !== 1'b0) $display("FAIL basic_flag got %b want 0", bus.out_flag); else passed++;
    total++; if (bus.out_op !== 2'b00) $display("FAIL basic_op got %b want 00", bus.out_op); else passed++;
    step();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_hold got %b want 1", bus.out_valid); else passed++;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_consume got %b want 0", bus.out_valid); else passed++;
  endtask

  // Vectors: add 15+1, sub 2-6, and A&6, xor A^6 with hand-computed results.
  task automatic test_ops();
    logic [1:0] op_t [4];
    logic [3:0] a_t  [4];
    logic [3:0] b_t  [4];
    logic [3:0] d_t  [4];
    logic       f_t  [4];
    bit ok;
    op_t = '{2'b00, 2'b01, 2'b10, 2'b11};
    a_t  = '{4'd15, 4'd2, 4'hA, 4'hA};
    b_t  = '{4'd1, 4'd6, 4'h6, 4'h6};
    d_t  = '{4'd0, 4'd12, 4'h2, 4'hC};
    f_t  = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      push(op_t[i], a_t[i], b_t[i], ok);
      wait_out(ok);
      total++;
      if (!ok) $display("FAIL ops%0d_timeout out_valid got 0 want 1", i);
      else passed++;
      total++; if (bus.out_data !== d_t[i]) $display("FAIL ops%0d_data got %h want %h", i, bus.out_data, d_t[i]); else passed++;
      total++; if (bus.out_flag !== f_t[i]) $display("FAIL ops%0d_flag got %b want %b", i, bus.out_flag, f_t[i]); else passed++;
      total++; if (bus.out_op !== op_t[i]) $display("FAIL ops%0d_op got %b want %b", i, bus.out_op, op_t[i]); else passed++;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_full_backpressure();
    logic [1:0] op_t [6];
    logic [3:0] a_t  [6];
    logic [3:0] b_t  [6];
    logic [3:0] d_t  [5];
    logic       f_t  [5];
    int accepted = 0;
    int seen = 0;
    int last_t = 0;
    op_t = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    a_t  = '{4'd1, 4'd9, 4'hF, 4'hC, 4'd8, 4'd7};
    b_t  = '{4'd2, 4'd4, 4'h6, 4'h3, 4'd9, 4'd7};
    d_t  = '{4'd3, 4'd5, 4'h6, 4'hF, 4'd1};
    f_t  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_op = op_t[i]; bus.in_a = a_t[i]; bus.in_b = b_t[i];
      if (bus.in_ready) accepted++;
      step();
    end
    total++; if (accepted !== 5) $display("FAIL full_accepted got %0d want 5", accepted); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.in_ready !== 1'b0) $display("FAIL full_ready%0d got %b want 0", i, bus.in_ready); else passed++;
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (bus.out_valid) begin
        if (seen < 5) begin
          total++; if (bus.out_data !== d_t[seen]) $display("FAIL full_data%0d got %h want %h", seen, bus.out_data, d_t[seen]); else passed++;
          total++; if (bus.out_flag !== f_t[seen]) $display("FAIL full_flag%0d got %b want %b", seen, bus.out_flag, f_t[seen]); else passed++;
          total++; if (bus.out_op !== op_t[seen]) $display("FAIL full_op%0d got %b want %b", seen, bus.out_op, op_t[seen]); else passed++;
          if (seen > 0) begin
            total++; if (t - last_t !== 3) $display("FAIL full_spacing%0d got %0d want 3", seen, t - last_t); else passed++;
          end
        end
        last_t = t;
        seen++;
      end
      step();
    end
    total++; if (seen !== 5) $display("FAIL full_result_count got %0d want 5", seen); else passed++;
    bus.out_ready = 1'b0;
  endtask

  // add a+0 returns a, so the results must count up in push order.
  task automatic test_simul_push_pop();
    bit ok;
    int nxt = 4;
    int res = 1;
    int accepted = 0;
    int seen = 0;
    for (int i = 1; i <= 3; i++) begin
      push(2'b00, 4'(i), 4'd0, ok);
      total++; if (!ok) $display("FAIL simul_push%0d in_ready got 0 want 1", i); else passed++;
    end
    for (int i = 0; i < 6; i++) begin
      wait_out(ok);
      total++; if (!ok) $display("FAIL simul_timeout%0d out_valid got 0 want 1", i); else passed++;
      total++; if (bus.out_data !== 4'(res)) $display("FAIL simul_data%0d got %h want %h", i, bus.out_data, 4'(res)); else passed++;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL simul_ready%0d got %b want 1", i, bus.in_ready); else passed++;
      bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_a = 4'(nxt); bus.in_b = 4'd0;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      res++;
      nxt++;
    end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_a = 4'(nxt + i); bus.in_b = 4'd0;
      if (bus.in_ready) accepted++;
      step();
    end
    bus.in_valid = 1'b0;
    total++; if (accepted !== 2) $display("FAIL simul_occupancy accepted got %0d want 2", accepted); else passed++;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (bus.out_valid) begin
        total++; if (bus.out_data !== 4'(res)) $display("FAIL simul_drain%0d got %h want %h", seen, bus.out_data, 4'(res)); else passed++;
        res++;
        seen++;
      end
      step();
    end
    total++; if (seen !== 5) $display("FAIL simul_drain_count got %0d want 5", seen); else passed++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    bit ok;
    int stale = 0;
    for (int i = 0; i < 4; i++) begin
      push(2'b00, 4'(i + 1), 4'd1, ok);
      total++; if (!ok) $display("FAIL mid_push%0d in_ready got 0 want 1", i); else passed++;
    end
    wait_out(ok);
    total++; if (!ok) $display("FAIL mid_timeout out_valid got 0 want 1"); else passed++;
    bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_a = 4'd9; bus.in_b = 4'd1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    total++; if (alu_drive !== 1'b1) $display("FAIL mid_drive1 got %b want 1", alu_drive); else passed++;
    step();
    total++; if (alu_drive !== 1'b1) $display("FAIL mid_drive2 got %b want 1", alu_drive); else passed++;
    rst = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (alu_drive !== 1'b0) $display("FAIL mid_alu_drive got %b want 0", alu_drive); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", bus.in_ready); else passed++;
    total++; if (alu_cmd !== 10'd0) $display("FAIL mid_cmd got %h want 000", alu_cmd); else passed++;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 15; t++) begin
      if (bus.out_valid || alu_drive) stale++;
      step();
    end
    total++; if (stale !== 0) $display("FAIL mid_stale_cycles got %0d want 0", stale); else passed++;
    bus.out_ready = 1'b0;
    push(2'b00, 4'd3, 4'd4, ok);
    wait_out(ok);
    total++; if (!ok) $display("FAIL mid_fresh_timeout out_valid got 0 want 1"); else passed++;
    total++; if (bus.out_data !== 4'd7) $display("FAIL mid_fresh_data got %h want 7", bus.out_data); else passed++;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op = 2'b00;
    bus.in_a = 4'd0;
    bus.in_b = 4'd0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_ops();
    test_full_backpressure();
    test_simul_push_pop();
    test_reset_mid_drive();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
